// File: rtl/mult_pkg.sv
// Shared types for the radix-4 Booth multiplier: FSM states, Booth digit
// encoding, digit-count derivation and the triple-to-digit recoding table.
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } mult_state_e;

  typedef enum logic [2:0] {
    BD_ZERO,
    BD_POS1,
    BD_POS2,
    BD_NEG1,
    BD_NEG2
  } booth_digit_e;

  // Operands are extended to WIDTH+2 bits, so WIDTH/2+1 digits cover them.
  function automatic int unsigned booth_digits(input int unsigned width);
    return width / 2 + 1;
  endfunction

  function automatic booth_digit_e booth_decode(input logic [2:0] triple);
    booth_digit_e d;
    case (triple)
      3'b001, 3'b010: d = BD_POS1;
      3'b011:         d = BD_POS2;
      3'b100:         d = BD_NEG2;
      3'b101, 3'b110: d = BD_NEG1;
      default:        d = BD_ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mult_booth_recoder.sv
// Combinational Booth recoder: maps a multiplier triple and the (already
// weighted) multiplicand to the signed partial-product addend.
module mult_booth_recoder
  import mult_pkg::*;
#(
  parameter int unsigned PW = 64
) (
  input  logic [2:0]    triple_i,
  input  logic [PW-1:0] mcand_i,
  output logic [PW-1:0] addend_o
);

  booth_digit_e digit;

  always_comb begin
    digit    = booth_decode(triple_i);
    addend_o = '0;
    case (digit)
      BD_POS1: addend_o = mcand_i;
      BD_POS2: addend_o = mcand_i << 1;
      BD_NEG1: addend_o = -mcand_i;
      BD_NEG2: addend_o = -(mcand_i << 1);
      default: addend_o = '0;
    endcase
  end

endmodule

// File: rtl/radix4_multiplier.sv
// Sequential radix-4 Booth multiplier, one digit per cycle, with a
// start/in_ready request side and productDone/out_ready result side.
// Optional feature: MULT_ACCUMULATE_EN adds acc_en (accumulate onto previous product).
module radix4_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
`ifdef MULT_ACCUMULATE_EN
  input  logic               acc_en,
`endif
  input  logic               start,
  output logic               in_ready,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   multiplicand,
  output logic [2*WIDTH-1:0] product,
  output logic               productDone,
  input  logic               out_ready,
  output logic               busy
);

  localparam int unsigned N  = booth_digits(WIDTH);
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned MW = WIDTH + 3;
  localparam int unsigned CW = $clog2(N + 1);

  mult_state_e   state_q, state_d;
  logic [PW-1:0] sum_q, sum_d;
  logic [PW-1:0] prod_q, prod_d;
  logic [PW-1:0] mcand_q, mcand_d;
  logic [MW-1:0] mplr_q, mplr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          sign_mp, sign_mc;
  logic [PW-1:0] mcand_ext;
  logic [MW-1:0] mplr_ext;
  logic [PW-1:0] addend;
  logic          acc_sel;

  // Extension to the full sum width is folded in here; unsigned operands
  // stay positive, so the signed Booth recoding is exact for both modes.
  assign sign_mp   = signed_mode & multiplier[WIDTH-1];
  assign sign_mc   = signed_mode & multiplicand[WIDTH-1];
  assign mcand_ext = {{WIDTH{sign_mc}}, multiplicand};
  assign mplr_ext  = {{2{sign_mp}}, multiplier, 1'b0};

`ifdef MULT_ACCUMULATE_EN
  assign acc_sel = acc_en;
`else
  assign acc_sel = 1'b0;
`endif

  mult_booth_recoder #(
    .PW(PW)
  ) u_recoder (
    .triple_i (mplr_q[2:0]),
    .mcand_i  (mcand_q),
    .addend_o (addend)
  );

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    prod_d  = prod_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sum_d   = acc_sel ? prod_q : '0;
          mcand_d = mcand_ext;
          mplr_d  = mplr_ext;
          cnt_d   = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        sum_d   = sum_q + addend;
        mcand_d = mcand_q << 2;
        mplr_d  = {{2{mplr_q[MW-1]}}, mplr_q[MW-1:2]};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          prod_d  = sum_q + addend;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sum_q   <= '0;
      prod_q  <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign product     = prod_q;
  assign in_ready    = (state_q == ST_IDLE);
  assign productDone = (state_q == ST_DONE);
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_radix4_multiplier.sv
// Scoreboard bench for radix4_multiplier at WIDTH=8: stimulus pushes expected
// products, a negedge monitor pops and compares on every result handshake.
module tb_radix4_multiplier;

  localparam int unsigned W = 8;
  localparam int unsigned N = W / 2 + 1;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic           signed_mode = 1'b0;
  logic           out_ready = 1'b1;
  logic [W-1:0]   multiplier = '0;
  logic [W-1:0]   multiplicand = '0;
  logic [2*W-1:0] product;
  logic           productDone, in_ready, busy;
`ifdef MULT_ACCUMULATE_EN
  logic           acc_en = 1'b0;
`endif

  int unsigned    vectors = 0;
  int unsigned    miscompares = 0;
  logic [2*W-1:0] exp_q[$];

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           sm;
    logic [2*W-1:0] p;
  } vec_t;
  vec_t vecs[9];

  radix4_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef MULT_ACCUMULATE_EN
    .acc_en       (acc_en),
`endif
    .start        (start),
    .in_ready     (in_ready),
    .signed_mode  (signed_mode),
    .multiplier   (multiplier),
    .multiplicand (multiplicand),
    .product      (product),
    .productDone  (productDone),
    .out_ready    (out_ready),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && productDone && out_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_result: got 0x%0h, expected no result", product);
      end else begin
        check("scoreboard_product", product, exp_q.pop_front());
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm, input logic acc);
    @(negedge clk);
    check("in_ready_before_accept", {15'd0, in_ready}, 16'd1);
    multiplier   = a;
    multiplicand = b;
    signed_mode  = sm;
`ifdef MULT_ACCUMULATE_EN
    acc_en       = acc;
`else
    if (acc) $display("note: accumulate requested without MULT_ACCUMULATE_EN");
`endif
    start = 1'b1;
    @(posedge clk);
    #1;
    start        = 1'b0;
    multiplier   = ~a;
    multiplicand = ~b;
    signed_mode  = ~sm;
  endtask

  task automatic wait_done(input string name, output int unsigned edges);
    edges = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (productDone) break;
    end
    if (!productDone) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got no productDone, expected it within 50 cycles", name);
    end
  endtask

  // The first edge that sees productDone is accept+N+1, i.e. it rises N edges after accept.
  task automatic run_job(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sm, input logic acc, input logic [2*W-1:0] exp);
    int unsigned edges;
    exp_q.push_back(exp);
    issue(a, b, sm, acc);
    check({name, "_busy"}, {15'd0, busy}, 16'd1);
    wait_done(name, edges);
    check({name, "_latency"}, 16'(edges), 16'(N));
    @(posedge clk);
    #1;
    check({name, "_idle_ready"}, {15'd0, in_ready}, 16'd1);
    check({name, "_idle_product"}, product, exp);
  endtask

  initial begin
    int unsigned edges;
    int unsigned done_seen;
    logic [2*W-1:0] snap;

    vecs[0] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    vecs[1] = '{8'h80, 8'h80, 1'b1, 16'h4000};
    vecs[2] = '{8'hFF, 8'h7F, 1'b1, 16'hFF81};
    vecs[3] = '{8'h00, 8'hC8, 1'b0, 16'h0000};
    vecs[4] = '{8'h80, 8'h7F, 1'b0, 16'h3F80};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
    vecs[6] = '{8'h80, 8'h01, 1'b1, 16'hFF80};
    vecs[7] = '{8'hFF, 8'h00, 1'b1, 16'h0000};
    vecs[8] = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};

    #1 rst = 1'b1;
    #1;
    check("reset_product", product, 16'h0000);
    check("reset_in_ready", {15'd0, in_ready}, 16'd1);
    check("reset_busy", {15'd0, busy}, 16'd0);
    check("reset_done", {15'd0, productDone}, 16'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++)
      run_job($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sm, 1'b0, vecs[i].p);

    // Hold in DONE with start pulses in CALC and DONE, then back-to-back request.
    out_ready = 1'b0;
    exp_q.push_back(16'hC080);
    issue(8'h80, 8'h7F, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check("calc_in_ready", {15'd0, in_ready}, 16'd0);
    multiplier   = 8'h01;
    multiplicand = 8'h01;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("hold", edges);
    snap = product;
    check("hold_first_product", snap, 16'hC080);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start      = i[0];
      multiplier = 8'(i);
      @(posedge clk);
      #1;
      check("hold_done", {15'd0, productDone}, 16'd1);
      check("hold_product", product, snap);
    end
    multiplier   = 8'd12;
    multiplicand = 8'd13;
    signed_mode  = 1'b0;
    start        = 1'b1;
    out_ready    = 1'b1;
    exp_q.push_back(16'h009C);
    @(posedge clk);
    #1;
    check("handshake_no_accept_ready", {15'd0, in_ready}, 16'd1);
    check("handshake_no_accept_busy", {15'd0, busy}, 16'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("next_accept_busy", {15'd0, busy}, 16'd1);
    wait_done("b2b", edges);
    check("b2b_latency", 16'(edges), 16'(N));
    @(posedge clk);
    #1;

    // Reset in CALC cycle 3 discards the job without a productDone.
    issue(8'd200, 8'd200, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_product", product, 16'h0000);
    check("abort_in_ready", {15'd0, in_ready}, 16'd1);
    check("abort_busy", {15'd0, busy}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (productDone) done_seen++;
    end
    check("abort_no_done", 16'(done_seen), 16'd0);
    run_job("after_abort", 8'd3, 8'd5, 1'b0, 1'b0, 16'd15);

`ifdef MULT_ACCUMULATE_EN
    run_job("acc_first", 8'd10, 8'd10, 1'b0, 1'b0, 16'd100);
    run_job("acc_second", 8'd3, 8'd4, 1'b0, 1'b1, 16'd112);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, expected finish within 100000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/radix4_multiplier.md
RADIX4_MULTIPLIER -- requirements
Module: radix4_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand width in bits; legal values are even and >= 4.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request valid.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept a request.
REQ-006 SHALL have port signed_mode, input, 1 bit: 1 treats operands as two's complement, 0 as unsigned.
REQ-007 SHALL have ports multiplier and multiplicand, input, WIDTH bits each: the operands.
REQ-008 SHALL have port product, output, 2*WIDTH bits: the result.
REQ-009 SHALL have port productDone, output, 1 bit: product valid.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts the product.
REQ-011 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-012 SHALL implement states IDLE, CALC and DONE; in_ready is high only in IDLE, and productDone is high only in DONE.
REQ-013 SHALL accept a request on an edge where start && in_ready; it latches both operands and signed_mode, clears the running sum, and moves to CALC.
REQ-014 SHALL ignore start and operand changes while in CALC or DONE.
REQ-015 SHALL sign-extend (signed) or zero-extend (unsigned) the operands to WIDTH+2 bits and process N = WIDTH/2+1 radix-4 Booth digits, one digit per cycle.
REQ-016 SHALL recode each digit from the multiplier triple {b(2i+1), b(2i), b(2i-1)}, with b(-1)=0, into one of {0, +M, +2M, -M, -2M}, and add it to the running sum with weight 4^i.
REQ-017 SHALL spend exactly N cycles in CALC; with the accept edge as cycle 0, productDone is high from cycle N+1 (N+1 = 18 for WIDTH=32).
REQ-018 SHALL present product equal to the exact product modulo 2^(2*WIDTH): the signed result when signed_mode was 1, the unsigned result when it was 0.
REQ-019 SHALL hold product and productDone stable in DONE until out_ready is high.
REQ-020 SHALL return to IDLE on the edge where productDone && out_ready; in_ready is high on the following cycle.
REQ-021 SHALL not accept a new request on the same edge as the DONE handshake, giving a minimum of one IDLE cycle between jobs.
REQ-022 SHALL keep the last product value on the product port while in IDLE, until the next accept.
REQ-023 SHALL compute correctly for the corner operands 0, all-ones, and the most negative value in signed mode.

Reset
REQ-024 SHALL, while rst is high, force state to IDLE, product to 0, productDone to 0, busy to 0 and in_ready to 1, independent of clk.
REQ-025 SHALL discard any in-flight job when rst is asserted during CALC or DONE, with no productDone pulse afterwards.

Configuration
REQ-026 SHALL, when macro MULT_ACCUMULATE_EN is defined, add input port acc_en (1 bit) latched at accept; with acc_en=1, the result is the previous product plus the new product, modulo 2^(2*WIDTH).
REQ-027 SHALL, when MULT_ACCUMULATE_EN is undefined, omit acc_en, and every job overwrites product.

Structure
REQ-028 SHALL take the state enum, the Booth digit encoding type and the localparam derivation of N from shared package mult_pkg.
REQ-029 SHALL instantiate one combinational sub-module mult_booth_recoder, which maps the 3-bit triple plus multiplicand to the signed partial-product addend.

Verification
REQ-030 SHALL check, with WIDTH=8 unsigned, 255*255: product = 0xFE01, productDone in cycle 6 after accept.
REQ-031 SHALL check, with WIDTH=8 signed, -128*-128 = 0x4000 and -1*127 = 0xFF81.
REQ-032 SHALL check that holding out_ready=0 for 10 cycles in DONE leaves product and productDone unchanged, and that start pulses in CALC and DONE are ignored.
REQ-033 SHALL check that rst asserted in CALC cycle 3 gives product=0 and in_ready=1 immediately, and that a following job 3*5 yields 15.
REQ-034 SHALL check, with MULT_ACCUMULATE_EN and WIDTH=8, job 10*10 then job 3*4 with acc_en=1: product = 112.
